qam_tx_symbol_gen: RTL and testbench

Transmit-side QAM symbol source that drives the carrier-recovery loop under test.
- Accepts 4-bit symbol words over a valid/ready handshake.
- Gray-maps each word to QPSK or 16-QAM I/Q levels, applies a quadrant carrier rotation from a phase accumulator (emulates carrier phase/frequency offset), and holds each symbol for OVERSAMPLE enabled cycles.
- Output feeds the receiver's InData re/im path, quantised to fixed point.

---
 rtl/qam_tx_symbol_gen.sv | 120 ++++++++++++
 tb/tb_qam_tx_symbol_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qam_tx_symbol_gen.sv
// Transmit QAM symbol source: Gray-maps 4-bit words to QPSK/16-QAM I/Q levels,
// rotates by a quadrant carrier phase and holds each symbol for OVERSAMPLE cycles.
module qam_tx_symbol_gen #(
  parameter int DATA_W     = 16,
  parameter int AMP        = 4096,
  parameter int OVERSAMPLE = 4,
  parameter int PHASE_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic [3:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mod_sel,
  input  logic [PHASE_W-1:0]       phase_step,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_valid,
  output logic                     sym_strobe
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam logic signed [DATA_W-1:0] LVL1 = DATA_W'(AMP);
  localparam logic signed [DATA_W-1:0] LVL2 = DATA_W'(2 * AMP);
  localparam logic signed [DATA_W-1:0] LVL3 = DATA_W'(3 * AMP);

  logic [0:0]               state_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [PHASE_W-1:0]       acc_r;
  logic                     accept_s;
  logic signed [DATA_W-1:0] i_s, q_s, rot_re_s, rot_im_s;

  // Gray mapping of one 2-bit 16-QAM field
  function automatic logic signed [DATA_W-1:0] map_qam16(input logic [1:0] bits);
    case (bits)
      2'b00:   return -LVL3;
      2'b01:   return -LVL1;
      2'b11:   return LVL1;
      2'b10:   return LVL3;
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] map_qpsk(input logic bit_v);
    if (bit_v) return LVL2;
    else       return -LVL2;
  endfunction

  // Handshake: ready in IDLE or on the last held sample so symbols can run back-to-back
  always_comb begin
    if (state_r == IDLE) in_ready = 1'b1;
    else                 in_ready = (cnt_r == CNT_LAST);
    accept_s = clk_enable & in_valid & in_ready;
  end

  // Map the incoming word and rotate by the current phase quadrant
  always_comb begin
    i_s      = '0;
    q_s      = '0;
    rot_re_s = '0;
    rot_im_s = '0;
    if (mod_sel) begin
      i_s = map_qam16(in_data[3:2]);
      q_s = map_qam16(in_data[1:0]);
    end else begin
      i_s = map_qpsk(in_data[1]);
      q_s = map_qpsk(in_data[0]);
    end
    case (acc_r[PHASE_W-1 -: 2])
      2'b00: begin rot_re_s = i_s;  rot_im_s = q_s;  end
      2'b01: begin rot_re_s = -q_s; rot_im_s = i_s;  end
      2'b10: begin rot_re_s = -i_s; rot_im_s = -q_s; end
      2'b11: begin rot_re_s = q_s;  rot_im_s = -i_s; end
      default: begin rot_re_s = '0; rot_im_s = '0; end
    endcase
  end

  // Symbol state, hold counter, phase accumulator and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      acc_r      <= '0;
      out_re     <= '0;
      out_im     <= '0;
      out_valid  <= 1'b0;
      sym_strobe <= 1'b0;
    end else if (clk_enable) begin
      if (accept_s) begin
        state_r    <= ACTIVE;
        cnt_r      <= '0;
        acc_r      <= acc_r + phase_step;
        out_re     <= rot_re_s;
        out_im     <= rot_im_s;
        out_valid  <= 1'b1;
        sym_strobe <= 1'b1;
      end else if (state_r == ACTIVE) begin
        if (cnt_r == CNT_LAST) begin
          // Underflow: no new symbol ready, go quiet
          state_r    <= IDLE;
          cnt_r      <= '0;
          out_re     <= '0;
          out_im     <= '0;
          out_valid  <= 1'b0;
          sym_strobe <= 1'b0;
        end else begin
          cnt_r      <= cnt_r + CNT_W'(1);
          sym_strobe <= 1'b0;
        end
      end else begin
        sym_strobe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qam_tx_symbol_gen.sv
// Scoreboard bench for qam_tx_symbol_gen: one OVERSAMPLE=4 and one OVERSAMPLE=1 instance.
module tb_qam_tx_symbol_gen;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               stb;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_enable = 1'b1;
  logic [3:0] in_data = 4'd0;
  logic mod_sel = 1'b0;
  logic [7:0] phase_step = 8'd0;
  logic in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic rdy0, rdy1, val0, val1, stb0, stb1;
  logic signed [15:0] re0, im0, re1, im1;

  exp_t q0[$];
  exp_t q1[$];
  int vectors = 0;
  int miscompares = 0;

  qam_tx_symbol_gen #(.DATA_W(16), .AMP(4096), .OVERSAMPLE(4), .PHASE_W(8)) u0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .in_data(in_data),
    .in_valid(in_valid0), .in_ready(rdy0), .mod_sel(mod_sel), .phase_step(phase_step),
    .out_re(re0), .out_im(im0), .out_valid(val0), .sym_strobe(stb0));

  qam_tx_symbol_gen #(.DATA_W(16), .AMP(4096), .OVERSAMPLE(1), .PHASE_W(8)) u1 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .in_data(in_data),
    .in_valid(in_valid1), .in_ready(rdy1), .mod_sel(mod_sel), .phase_step(phase_step),
    .out_re(re1), .out_im(im1), .out_valid(val1), .sym_strobe(stb1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic mon(input int w, input logic v, input logic s,
                     input logic signed [15:0] re, input logic signed [15:0] im);
    exp_t e;
    int pending;
    pending = (w == 0) ? q0.size() : q1.size();
    vectors++;
    if (v) begin
      if (pending == 0) begin
        miscompares++;
        $display("FAIL dut%0d unexpected_sample: got (%0d,%0d) stb=%0b expected none", w, re, im, s);
      end else begin
        e = (w == 0) ? q0.pop_front() : q1.pop_front();
        if (re !== e.re || im !== e.im || s !== e.stb) begin
          miscompares++;
          $display("FAIL dut%0d sample: got (%0d,%0d) stb=%0b expected (%0d,%0d) stb=%0b",
                   w, re, im, s, e.re, e.im, e.stb);
        end
      end
    end else if (re !== 16'sd0 || im !== 16'sd0 || s !== 1'b0 || pending != 0) begin
      miscompares++;
      $display("FAIL dut%0d idle: got (%0d,%0d) stb=%0b pending=%0d expected (0,0) stb=0 pending=0",
               w, re, im, s, pending);
    end
  endtask

  // Monitors: inspect every enabled edge shortly after it
  always @(posedge clk) begin
    if (!reset && clk_enable) begin
      #1;
      mon(0, val0, stb0, re0, im0);
      mon(1, val1, stb1, re1, im1);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input int w, input logic [3:0] d, input logic m, input logic [7:0] st,
                      input logic signed [15:0] er, input logic signed [15:0] ei);
    int t;
    exp_t e;
    in_data = d;
    mod_sel = m;
    phase_step = st;
    if (w == 0) in_valid0 = 1'b1;
    else        in_valid1 = 1'b1;
    t = 0;
    while (!(((w == 0) ? rdy0 : rdy1) && clk_enable) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL dut%0d send_timeout: got in_ready=0 expected 1 within 50 cycles", w);
    end else begin
      for (int k = 0; k < ((w == 0) ? 4 : 1); k++) begin
        e.re = er;
        e.im = ei;
        e.stb = (k == 0);
        if (w == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic signed [15:0] lv16(input logic [1:0] b);
    case (b)
      2'b00:   return -16'sd12288;
      2'b01:   return -16'sd4096;
      2'b11:   return 16'sd4096;
      default: return 16'sd12288;
    endcase
  endfunction

  initial begin
    logic [7:0] acc1;
    logic [6:0] pat;
    logic [3:0] d;
    logic [7:0] st;
    logic m;
    logic signed [15:0] ii, qq, er, ei;
    int n;

    // Reset state
    #1;
    chk("reset_re", re0, 0);
    chk("reset_im", im0, 0);
    chk("reset_valid", val0, 0);
    chk("reset_strobe", stb0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("ready_after_reset0", rdy0, 1);
    chk("ready_after_reset1", rdy1, 1);

    // Single 16-QAM symbol, then underflow to idle
    send(0, 4'b1001, 1'b1, 8'h00, 16'sd12288, -16'sd4096);
    idle(8);

    // QPSK back-to-back with quarter-turn steps
    send(0, 4'b0011, 1'b0, 8'h40, 16'sd8192, 16'sd8192);
    send(0, 4'b0011, 1'b0, 8'h40, -16'sd8192, 16'sd8192);
    send(0, 4'b0011, 1'b0, 8'h40, -16'sd8192, -16'sd8192);
    send(0, 4'b0011, 1'b0, 8'h40, 16'sd8192, -16'sd8192);
    idle(6);

    // clk_enable toggling during a held symbol
    send(0, 4'b0110, 1'b1, 8'h00, -16'sd4096, 16'sd12288);
    in_valid0 = 1'b0;
    pat = 7'b1100101;
    n = 0;
    for (int k = 0; k < 7; k++) begin
      chk("ready_during_hold", rdy0, (n >= 3) ? 1 : 0);
      clk_enable = pat[k];
      @(negedge clk);
      if (pat[k]) n++;
    end
    clk_enable = 1'b1;
    idle(4);

    // Gap of idle cycles, then immediate restart
    send(0, 4'b0000, 1'b0, 8'h00, -16'sd8192, -16'sd8192);
    idle(7);
    send(0, 4'b0010, 1'b0, 8'h00, 16'sd8192, -16'sd8192);
    idle(6);

    // Reset in the middle of a rotated 16-QAM symbol
    send(0, 4'b1001, 1'b1, 8'h40, 16'sd12288, -16'sd4096);
    send(0, 4'b0000, 1'b1, 8'h00, 16'sd12288, -16'sd12288);
    in_valid0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_re", re0, 0);
    chk("midreset_im", im0, 0);
    chk("midreset_valid", val0, 0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset = 1'b0;
    send(0, 4'b1010, 1'b1, 8'h00, 16'sd12288, 16'sd12288);
    idle(6);

    // OVERSAMPLE=1 random stream against a reference model
    acc1 = 8'h00;
    for (int s = 0; s < 1000; s++) begin
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        clk_enable = ($urandom_range(0, 3) != 0);
        @(negedge clk);
      end
      clk_enable = 1'b1;
      d = 4'($urandom);
      st = 8'($urandom);
      m = 1'($urandom);
      if (m) begin
        ii = lv16(d[3:2]);
        qq = lv16(d[1:0]);
      end else begin
        ii = d[1] ? 16'sd8192 : -16'sd8192;
        qq = d[0] ? 16'sd8192 : -16'sd8192;
      end
      case (acc1[7:6])
        2'b00:   begin er = ii;  ei = qq;  end
        2'b01:   begin er = -qq; ei = ii;  end
        2'b10:   begin er = -ii; ei = -qq; end
        default: begin er = qq;  ei = -ii; end
      endcase
      send(1, d, m, st, er, ei);
      acc1 = acc1 + st;
    end
    idle(6);

    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
